seq_approx_array_divider: RTL

//  Iterative, parametrised restoring divider: N_W-bit dividend / D_W-bit divisor -> Q_W quotient, D_W remainder.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_row.sv | 43 ++++
 rtl/seq_approx_array_divider.sv | 137 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential approximate array divider.
//   state_t     : control FSM states
//   cell_t      : one subtractor-cell result (borrow out, difference bit)
//   exact_cell  : full-subtractor cell
//   approx_cell : approximate cell; passes the minuend through and
//                 produces a borrow that ignores the subtrahend bit
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic bout;
        logic diff;
    } cell_t;

    function automatic cell_t exact_cell(input logic x, input logic y, input logic bin);
        cell_t c;
        c.diff = x ^ y ^ bin;
        c.bout = (~x & y) | (~(x ^ y) & bin);
        return c;
    endfunction

    function automatic cell_t approx_cell(input logic x, input logic bin);
        cell_t c;
        c.diff = x;
        c.bout = x | ~bin;
        return c;
    endfunction

endpackage

// File: rtl/div_row.sv
// One restoring-division iteration (purely combinational).
//   i_t     : partial remainder with next dividend bit appended, D_W+1 bits
//   i_d     : divisor
//   i_amask : per-column select, 1 = approximate cell in that column
//   o_q     : quotient bit for this iteration
//   o_r     : next partial remainder
module div_row
    import div_pkg::*;
#(
    parameter int D_W = 8
) (
    input  logic [D_W:0]   i_t,
    input  logic [D_W-1:0] i_d,
    input  logic [D_W-1:0] i_amask,
    output logic           o_q,
    output logic [D_W-1:0] o_r
);

    logic [D_W-1:0] w_diff;
    logic           w_bout;

    // Ripple borrow across the row; a local variable keeps the chain
    // inside one process.
    always_comb begin
        logic  b;
        cell_t c;
        b      = 1'b0;
        c      = '0;
        w_diff = '0;
        for (int j = 0; j < D_W; j++) begin
            c         = i_amask[j] ? approx_cell(i_t[j], b) : exact_cell(i_t[j], i_d[j], b);
            w_diff[j] = c.diff;
            b         = c.bout;
        end
        w_bout = b;
    end

    // The top bit of T covers the case where the D_W-bit subtraction
    // borrows but the full D_W+1-bit value still exceeds the divisor.
    assign o_q = i_t[D_W] | ~w_bout;
    assign o_r = o_q ? w_diff : i_t[D_W-1:0];

endmodule

// File: rtl/seq_approx_array_divider.sv
// Iterative restoring divider, ITER_PER_CYCLE quotient bits per clock,
// MSB first, with optional approximate cells in the low-order rows/columns.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_in_valid        : operands valid          o_in_ready : idle, accepting
//   i_n, i_d          : dividend (D_W+Q_W), divisor (D_W)
//   i_approx_en       : enable approximate rows for this operation
//   o_out_valid       : result valid            i_out_ready: consumer accepts
//   o_q, o_r          : quotient, remainder
//   o_dbz, o_ovf      : divisor zero, quotient overflow (flags only)
module seq_approx_array_divider
    import div_pkg::*;
#(
    parameter int D_W            = 8,
    parameter int Q_W            = 8,
    parameter int ITER_PER_CYCLE = 1,
    parameter int APPROX_ROWS    = 4,
    parameter int APPROX_COLS    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [D_W+Q_W-1:0] i_n,
    input  logic [D_W-1:0]     i_d,
    input  logic               i_approx_en,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [Q_W-1:0]     o_q,
    output logic [D_W-1:0]     o_r,
    output logic               o_dbz,
    output logic               o_ovf
);

    localparam int N_W = D_W + Q_W;
    localparam int KW  = (Q_W > 1) ? $clog2(Q_W) : 1;

    state_t          r_state, w_next;
    logic [KW-1:0]   r_k;
    logic [D_W-1:0]  r_rem;
    logic [Q_W-1:0]  r_nq;     // unused dividend bits on top, quotient bits shift in below
    logic [D_W-1:0]  r_d;
    logic            r_apx;
    logic            r_dbz;
    logic            r_ovf;

    logic [ITER_PER_CYCLE:0][D_W-1:0]   w_rem;
    logic [ITER_PER_CYCLE-1:0]          w_qb;
    logic [ITER_PER_CYCLE-1:0][D_W-1:0] w_amask;
    logic [Q_W-1:0]                     w_nq_next;
    logic                               w_last;

    // Stage s of this clock handles iteration k-s.
    always_comb begin
        w_amask = '0;
        for (int s = 0; s < ITER_PER_CYCLE; s++) begin
            for (int j = 0; j < D_W; j++) begin
                if (r_apx && (j < APPROX_COLS) && ((int'(r_k) - s) < APPROX_ROWS))
                    w_amask[s][j] = 1'b1;
            end
        end
    end

    assign w_rem[0] = r_rem;

    for (genvar s = 0; s < ITER_PER_CYCLE; s++) begin : g_row
        div_row #(.D_W(D_W)) u_row (
            .i_t     ({w_rem[s], r_nq[Q_W-1-s]}),
            .i_d     (r_d),
            .i_amask (w_amask[s]),
            .o_q     (w_qb[s]),
            .o_r     (w_rem[s+1])
        );
    end

    // Consumed dividend bits leave the top; new quotient bits enter the
    // bottom, so after Q_W iterations r_nq holds the complete quotient.
    always_comb begin
        w_nq_next = r_nq << ITER_PER_CYCLE;
        for (int s = 0; s < ITER_PER_CYCLE; s++)
            w_nq_next[ITER_PER_CYCLE-1-s] = w_qb[s];
    end

    assign w_last = (r_k == KW'(ITER_PER_CYCLE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_in_valid)  w_next = RUN;
            RUN:     if (w_last)      w_next = DONE;
            DONE:    if (i_out_ready) w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_rem <= '0;
            r_nq  <= '0;
            r_d   <= '0;
            r_apx <= 1'b0;
            r_dbz <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_in_valid) begin
                    r_rem <= i_n[N_W-1:Q_W];
                    r_nq  <= i_n[Q_W-1:0];
                    r_d   <= i_d;
                    r_apx <= i_approx_en;
                    r_k   <= KW'(Q_W - 1);
                    r_dbz <= (i_d == '0);
                    r_ovf <= (i_n[N_W-1:Q_W] >= i_d);
                end
                RUN: begin
                    r_rem <= w_rem[ITER_PER_CYCLE];
                    r_nq  <= w_nq_next;
                    r_k   <= r_k - KW'(ITER_PER_CYCLE);
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready  = (r_state == IDLE);
    assign o_out_valid = (r_state == DONE);
    assign o_q         = r_nq;
    assign o_r         = r_rem;
    assign o_dbz       = r_dbz;
    assign o_ovf       = r_ovf;

endmodule
